calc1_port_driver: RTL and testbench
====================================

// Module: calc1_port_driver
// PURPOSE
//  Requester side of one calc1 command port: accepts an operation (cmd, op1, op2, tag) from a host
//  over a valid/ready handshake, drives the two-cycle request onto req_cmd_in/req_data_in, then
//  waits for the calc1 response (out_resp/out_data) and returns it to the host with a timeout.
//  One instance per calc1 port (1..4); used by directed and random benches and any future host
//  logic. At most one operation is outstanding per instance.
// PARAMETERS
//  TIMEOUT  64  max cycles spent in WAIT before the operation completes as timed out (>=2)
// PORTS
//  c_clk         in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-high reset
//  host_valid    in   1   host operation valid
//  host_ready    out  1   driver can accept an operation
//  host_cmd      in   [0:3]   command: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; others forwarded as-is
//  host_op1      in   [0:31]  operand 1 (sent with the command)
//  host_op2      in   [0:31]  operand 2 (sent the following cycle)
//  host_tag      in   [0:1]   opaque tag, returned with the result
//  req_cmd_out   out  [0:3]   to calc1 req_cmd_in[n]
//  req_data_out  out  [0:31]  to calc1 req_data_in[n]
//  dut_resp      in   [0:1]   from calc1 out_resp[n]: 0 none, 1 success, 2 invalid/overflow, 3 internal error
//  dut_data      in   [0:31]  from calc1 out_data[n]
//  res_valid     out  1   result valid; held until res_ready
//  res_ready     in   1   host accepts result
//  res_resp      out  [0:1]   captured dut_resp (0 on timeout or NOP)
//  res_data      out  [0:31]  captured dut_data (0 on timeout or NOP)
//  res_tag       out  [0:1]   tag of the completed operation
//  res_timeout   out  1   operation completed by timeout
//  err_spurious  out  1   sticky: nonzero dut_resp sampled outside WAIT
// BEHAVIOUR
//  - Reset: state IDLE, timer 0; every output 0 (host_ready becomes 1 in first cycle after reset
//    deasserts); latched op discarded. Reset mid-operation aborts it; no result is returned.
//  - All outputs registered. States: IDLE, SEND1, SEND2, WAIT, RESULT.
//  - IDLE: host_ready=1, req_cmd_out=0, req_data_out=0. On posedge with host_valid=1: latch
//    cmd/op1/op2/tag; cmd!=0 -> SEND1; cmd==0 -> RESULT with res_resp=0, res_data=0, res_timeout=0
//    (no calc1 traffic). host_ready=0 in every other state.
//  - SEND1 (1 cycle): req_cmd_out=cmd, req_data_out=op1 -> SEND2.
//  - SEND2 (1 cycle): req_cmd_out=0, req_data_out=op2 -> WAIT, timer cleared.
//    Handshake at edge k => cmd on port in cycle k+1, op2 in cycle k+2, first WAIT cycle k+3.
//  - WAIT: req_cmd_out=0, req_data_out=0. Each cycle: dut_resp!=0 -> capture resp/data, RESULT;
//    else timer+1; on the TIMEOUT-th WAIT cycle with dut_resp==0 -> RESULT, res_timeout=1,
//    res_resp=0, res_data=0. Response in the same cycle as the TIMEOUT-th tick wins (no timeout).
//  - RESULT: res_valid=1, res_* stable. On posedge with res_ready=1 -> IDLE; res_valid, res_*
//    return to 0 the next cycle. No bypass: new op can be accepted no earlier than the cycle after.
//  - dut_resp!=0 sampled in IDLE/SEND1/SEND2/RESULT: sets err_spurious (cleared only by reset),
//    value ignored; result of the current op unaffected.
//  - Driver never alters data or interprets result; overflow/invalid reported only via res_resp.
//  - Timer width $clog2(TIMEOUT+1); no wrap possible.
// TESTING
//  1. ADD: cmd=1 op1=1 op2=2 tag=2; model answers resp=1 data=3 in 3rd WAIT cycle -> req_cmd_out=1
//     exactly one cycle, data 1 then 2; res_valid with resp=1 data=3 tag=2 timeout=0.
//  2. Timeout: cmd=2 op1=5 op2=9, dut_resp held 0 -> res_valid after exactly 64 WAIT cycles,
//     res_timeout=1, res_resp=0, res_data=0; response at WAIT cycle 64 instead -> timeout=0.
//  3. Backpressure: res_ready=0 for 10 cycles after res_valid -> res_* stable, host_ready=0,
//     req_cmd_out=0 throughout; res_ready=1 -> IDLE, host_ready=1 next cycle.
//  4. NOP: cmd=0 -> no nonzero req_cmd_out, res_valid next cycle with resp=0, timeout=0, tag echoed.
//  5. Reset in WAIT, then late dut_resp=1 in IDLE -> all outputs 0 after reset, no res_valid,
//     err_spurious=1 and held until next reset.
//  6. Invalid cmd=4 op1=0xFFFFFFFF op2=1 -> cmd 4 forwarded unchanged; model resp=2 -> res_resp=2.

Source files
------------

// File: rtl/calc1_port_driver.sv
`default_nettype none
// ============================================================================
// Module      : calc1_port_driver
// Description : Requester side of one calc1 command port. Accepts one host
//               operation, sends it as a two-cycle request, waits for the calc1
//               response (bounded by TIMEOUT) and holds the result for the host.
// Revision    : 1.0  initial release
// ============================================================================
module calc1_port_driver #(
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [3:0]  host_cmd,
  input  logic [31:0] host_op1,
  input  logic [31:0] host_op2,
  input  logic [1:0]  host_tag,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  dut_resp,
  input  logic [31:0] dut_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic [1:0]  res_tag,
  output logic        res_timeout,
  output logic        err_spurious
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND1  = 3'd1;
  localparam logic [2:0] S_SEND2  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [1:0]    tag_q, tag_d;

  logic          host_ready_q, host_ready_d;
  logic [3:0]    req_cmd_q, req_cmd_d;
  logic [31:0]   req_data_q, req_data_d;
  logic          res_valid_q, res_valid_d;
  logic [1:0]    res_resp_q, res_resp_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [1:0]    res_tag_q, res_tag_d;
  logic          res_timeout_q, res_timeout_d;
  logic          err_q, err_d;

  logic          w_accept;
  logic          w_resp_hit;
  logic          w_timer_last;

  // Handshake only counts once the registered ready has actually been shown.
  assign w_accept     = (state_q == S_IDLE) && host_ready_q && host_valid;
  assign w_resp_hit   = (dut_resp != 2'd0);
  assign w_timer_last = (timer_q == TW'(TIMEOUT - 1));

  // State, latched operation and all registered outputs.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      cmd_q         <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      tag_q         <= '0;
      host_ready_q  <= 1'b0;
      req_cmd_q     <= '0;
      req_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_resp_q    <= '0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      res_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      tag_q         <= tag_d;
      host_ready_q  <= host_ready_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      res_valid_q   <= res_valid_d;
      res_resp_q    <= res_resp_d;
      res_data_q    <= res_data_d;
      res_tag_q     <= res_tag_d;
      res_timeout_q <= res_timeout_d;
      err_q         <= err_d;
    end
  end

  // Next state, WAIT timer and operation latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          cmd_d   = host_cmd;
          op1_d   = host_op1;
          op2_d   = host_op2;
          tag_d   = host_tag;
          // A NOP never touches calc1 and completes immediately.
          state_d = (host_cmd != 4'd0) ? S_SEND1 : S_RESULT;
        end
      end
      S_SEND1: state_d = S_SEND2;
      S_SEND2: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // A response on the last tick still wins over the timeout.
        if (w_resp_hit || w_timer_last) begin
          state_d = S_RESULT;
        end
        if (!w_resp_hit && !w_timer_last) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    host_ready_d  = (state_d == S_IDLE);
    req_cmd_d     = (state_d == S_SEND1) ? cmd_d : 4'd0;
    req_data_d    = '0;
    if (state_d == S_SEND1) begin
      req_data_d = op1_d;
    end else if (state_d == S_SEND2) begin
      req_data_d = op2_d;
    end
    res_valid_d   = (state_d == S_RESULT);
    res_resp_d    = '0;
    res_data_d    = '0;
    res_tag_d     = '0;
    res_timeout_d = 1'b0;
    if (state_d == S_RESULT) begin
      res_tag_d = tag_d;
      if (state_q == S_RESULT) begin
        res_resp_d    = res_resp_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
      end else if (state_q == S_WAIT) begin
        // On timeout dut_resp is zero; data is forced to zero as well.
        res_resp_d    = dut_resp;
        res_data_d    = w_resp_hit ? dut_data : 32'd0;
        res_timeout_d = !w_resp_hit;
      end
    end
    // Responses arriving when none is awaited are flagged and otherwise ignored.
    err_d = err_q | (w_resp_hit && (state_q != S_WAIT));
  end

  assign host_ready   = host_ready_q;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign res_valid    = res_valid_q;
  assign res_resp     = res_resp_q;
  assign res_data     = res_data_q;
  assign res_tag      = res_tag_q;
  assign res_timeout  = res_timeout_q;
  assign err_spurious = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc1_port_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc1_port_driver
// Description : Self-checking bench for calc1_port_driver. Stimulus is issued
//               transaction by transaction; expected outputs for every cycle
//               follow from the transaction timeline and are compared on the
//               falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_calc1_port_driver;

  localparam int TIMEOUT = 64;

  logic        c_clk;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [3:0]  host_cmd;
  logic [31:0] host_op1;
  logic [31:0] host_op2;
  logic [1:0]  host_tag;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  dut_resp;
  logic [31:0] dut_data;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic        res_timeout;
  logic        err_spurious;

  calc1_port_driver #(.TIMEOUT(TIMEOUT)) u_dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_cmd     (host_cmd),
    .host_op1     (host_op1),
    .host_op2     (host_op2),
    .host_tag     (host_tag),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .dut_resp     (dut_resp),
    .dut_data     (dut_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_resp     (res_resp),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .res_timeout  (res_timeout),
    .err_spurious (err_spurious)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  int          tests = 0;
  int          fails = 0;
  logic        chk_en = 1'b0;
  int          pin_sel = 0;
  logic        spur_now = 1'b0;

  logic        exp_host_ready;
  logic [3:0]  exp_req_cmd;
  logic [31:0] exp_req_data;
  logic        exp_rv;
  logic [1:0]  exp_rresp;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rtag;
  logic        exp_rto;
  logic        exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison, a small monitor, and literal pins of known scenarios.
  initial begin : p_compare
    int          ncyc;
    int          cmd_cycles;
    int          cmd_at;
    int          rv_at;
    logic        prev_rv;
    logic [3:0]  last_cmd;
    logic [31:0] first_data;
    logic [1:0]  cap_resp;
    logic [31:0] cap_data;
    logic [1:0]  cap_tag;
    logic        cap_to;
    ncyc = 0; cmd_cycles = 0; cmd_at = 0; rv_at = 0; prev_rv = 1'b0;
    last_cmd = '0; first_data = '0; cap_resp = '0; cap_data = '0; cap_tag = '0; cap_to = 1'b0;
    forever begin
      @(negedge c_clk);
      ncyc++;
      if (chk_en) begin
        chk("host_ready",   32'(host_ready),   32'(exp_host_ready));
        chk("req_cmd_out",  32'(req_cmd_out),  32'(exp_req_cmd));
        chk("req_data_out", req_data_out,      exp_req_data);
        chk("res_valid",    32'(res_valid),    32'(exp_rv));
        chk("res_resp",     32'(res_resp),     32'(exp_rresp));
        chk("res_data",     res_data,          exp_rdata);
        chk("res_tag",      32'(res_tag),      32'(exp_rtag));
        chk("res_timeout",  32'(res_timeout),  32'(exp_rto));
        chk("err_spurious", 32'(err_spurious), 32'(exp_err));
      end
      if (req_cmd_out != 4'd0) begin
        cmd_cycles++;
        cmd_at     = ncyc;
        last_cmd   = req_cmd_out;
        first_data = req_data_out;
      end
      if (res_valid && !prev_rv) rv_at = ncyc;
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
        cap_resp = res_resp; cap_data = res_data; cap_tag = res_tag; cap_to = res_timeout;
      end
      case (pin_sel)
        1: cmd_cycles = 0;
        2: begin
          chk("add_cmd_cycles", 32'(cmd_cycles), 32'd1);
          chk("add_latency",    32'(rv_at - cmd_at), 32'd5);
          chk("add_op1_word",   first_data, 32'd1);
          chk("add_resp",       32'(cap_resp), 32'd1);
          chk("add_data",       cap_data, 32'd3);
          chk("add_tag",        32'(cap_tag), 32'd2);
          chk("add_timeout",    32'(cap_to), 32'd0);
        end
        3: begin
          chk("to_latency", 32'(rv_at - cmd_at), 32'd66);
          chk("to_flag",    32'(cap_to), 32'd1);
          chk("to_resp",    32'(cap_resp), 32'd0);
          chk("to_data",    cap_data, 32'd0);
        end
        4: begin
          chk("late64_latency", 32'(rv_at - cmd_at), 32'd66);
          chk("late64_flag",    32'(cap_to), 32'd0);
          chk("late64_data",    cap_data, 32'h0000000E);
        end
        5: begin
          chk("nop_cmd_cycles", 32'(cmd_cycles), 32'd0);
          chk("nop_tag",        32'(cap_tag), 32'd3);
          chk("nop_resp",       32'(cap_resp), 32'd0);
          chk("nop_timeout",    32'(cap_to), 32'd0);
        end
        6: begin
          chk("inv_cmd",  32'(last_cmd), 32'd4);
          chk("inv_op1",  first_data, 32'hFFFFFFFF);
          chk("inv_resp", 32'(cap_resp), 32'd2);
        end
        7: begin
          chk("rst_err_sticky", 32'(err_spurious), 32'd1);
          chk("rst_no_result",  32'(res_valid), 32'd0);
        end
        default: ;
      endcase
    end
  end

  // Advance one cycle: inputs return to idle with random don't-care data, and
  // per-cycle expectations default to the quiet values.
  task automatic cyc();
    @(posedge c_clk);
    #1;
    if (reset) exp_err = 1'b0;
    else if (spur_now) exp_err = 1'b1;
    spur_now       = 1'b0;
    host_valid     = 1'b0;
    res_ready      = 1'b0;
    dut_resp       = 2'd0;
    dut_data       = $urandom;
    host_cmd       = 4'($urandom);
    host_op1       = $urandom;
    host_op2       = $urandom;
    host_tag       = 2'($urandom);
    exp_host_ready = 1'b0;
    exp_req_cmd    = 4'd0;
    exp_req_data   = 32'd0;
    exp_rv         = 1'b0;
    exp_rresp      = 2'd0;
    exp_rdata      = 32'd0;
    exp_rtag       = 2'd0;
    exp_rto        = 1'b0;
    pin_sel        = 0;
  endtask

  task automatic spur();
    dut_resp = 2'($urandom_range(1, 3));
    spur_now = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      exp_host_ready = 1'b1;
    end
  endtask

  // One full operation, entered in an idle cycle. lat = WAIT cycle carrying the
  // response (0 or >TIMEOUT: none); bp = cycles of res_ready low; sm = spurious
  // response in idle / send1 / send2 / first result cycle.
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [1:0] tag, input int lat, input logic [1:0] rsp,
                       input logic [31:0] rdata, input int bp, input logic [3:0] sm);
    logic        got;
    logic [1:0]  eresp;
    logic [31:0] edata;
    exp_host_ready = 1'b1;
    host_valid = 1'b1; host_cmd = cmd; host_op1 = op1; host_op2 = op2; host_tag = tag;
    if (sm[0]) spur();
    cyc();
    got = 1'b0; eresp = 2'd0; edata = 32'd0;
    if (cmd != 4'd0) begin
      exp_req_cmd = cmd; exp_req_data = op1;
      if (sm[1]) spur();
      cyc();
      exp_req_data = op2;
      if (sm[2]) spur();
      cyc();
      for (int i = 1; i <= TIMEOUT; i++) begin
        if (i == lat) begin
          dut_resp = rsp; dut_data = rdata;
          got = 1'b1; eresp = rsp; edata = rdata;
        end
        cyc();
        if (got) break;
      end
    end
    for (int b = 0; b <= bp; b++) begin
      exp_rv = 1'b1; exp_rresp = eresp; exp_rdata = edata; exp_rtag = tag;
      exp_rto = (cmd != 4'd0) && !got;
      res_ready = (b == bp);
      if (sm[3] && b == 0) spur();
      cyc();
    end
    exp_host_ready = 1'b1;
  endtask

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int r, lat, gap;
    reset = 1'b1; host_valid = 1'b0; res_ready = 1'b0; dut_resp = 2'd0; dut_data = 32'd0;
    host_cmd = 4'd0; host_op1 = 32'd0; host_op2 = 32'd0; host_tag = 2'd0;
    exp_host_ready = 1'b0; exp_req_cmd = 4'd0; exp_req_data = 32'd0; exp_rv = 1'b0;
    exp_rresp = 2'd0; exp_rdata = 32'd0; exp_rtag = 2'd0; exp_rto = 1'b0; exp_err = 1'b0;
    @(posedge c_clk);
    #1;
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    exp_host_ready = 1'b1;

    // ADD with response in the third WAIT cycle.
    pin_sel = 1;
    do_op(4'd1, 32'd1, 32'd2, 2'd2, 3, 2'd1, 32'd3, 0, 4'd0);
    pin_sel = 2;
    idle(1);

    // Timeout, then a response exactly on the last WAIT cycle.
    pin_sel = 1;
    do_op(4'd2, 32'd5, 32'd9, 2'd1, 0, 2'd0, 32'd0, 0, 4'd0);
    pin_sel = 3;
    idle(1);
    pin_sel = 1;
    do_op(4'd2, 32'd5, 32'd9, 2'd3, TIMEOUT, 2'd1, 32'h0000000E, 0, 4'd0);
    pin_sel = 4;
    idle(1);

    // Backpressure for 10 cycles.
    do_op(4'd5, 32'd1, 32'd4, 2'd1, 2, 2'd1, 32'h10, 10, 4'd0);

    // NOP.
    pin_sel = 1;
    do_op(4'd0, 32'hDEAD, 32'hBEEF, 2'd3, 0, 2'd0, 32'd0, 1, 4'd0);
    pin_sel = 5;
    idle(1);

    // Unsupported command forwarded, overflow/invalid response returned.
    pin_sel = 1;
    do_op(4'd4, 32'hFFFFFFFF, 32'd1, 2'd0, 2, 2'd2, 32'd0, 0, 4'd0);
    pin_sel = 6;
    idle(1);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) lat = 0;
      else if (r == 1) lat = TIMEOUT;
      else lat = $urandom_range(1, 8);
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 2'($urandom),
            lat, 2'($urandom_range(1, 3)), $urandom, $urandom_range(0, 3),
            4'($urandom & $urandom));
      gap = $urandom_range(0, 2);
      idle(gap);
    end

    // Reset during WAIT, then a late response while idle.
    idle(1);
    exp_host_ready = 1'b1;
    host_valid = 1'b1; host_cmd = 4'd1; host_op1 = 32'd7; host_op2 = 32'd8; host_tag = 2'd1;
    cyc();
    exp_req_cmd = 4'd1; exp_req_data = 32'd7;
    cyc();
    exp_req_data = 32'd8;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    exp_host_ready = 1'b1;
    dut_resp = 2'd1; spur_now = 1'b1;
    idle(5);
    pin_sel = 7;
    idle(1);

    @(negedge c_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
